// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter sharing the VGA framebuffer write port between NREQ pixel writers.
// Define FB_ARB_ADDR_CHECK_EN to drop beats addressed at or beyond FB_DEPTH and count them on err_cnt.
//
// state | meaning
// IDLE  | no grant; pick next requester after ptr_q
// BURST | gnt_q owns the port; beats paced by VGA_ready

module fb_write_arbiter #(
  parameter int NREQ      = 3,
  parameter int AW        = 19,
  parameter int DW        = 3,
  parameter int MAX_BURST = 640,
  parameter int FB_DEPTH  = 307200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  input  logic               VGA_ready,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic               wr_en,
  output logic [AW-1:0]      wr_addr,
  output logic [DW-1:0]      wr_data,
  output logic               busy
`ifdef FB_ARB_ADDR_CHECK_EN
  ,
  output logic [7:0]         err_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  if (NREQ < 2 || NREQ > 8 || MAX_BURST < 1 || MAX_BURST > 65535 || FB_DEPTH < 1) begin : g_param_err
    $error("fb_write_arbiter: parameter out of range");
  end

  state_t          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [IW-1:0]   gidx_q;
  logic [IW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;

  logic            sel_req;
  logic            sel_last;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            beat;
  logic            burst_end;
  logic            in_range;
  logic            pick_vld;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;

  assign sel_req   = req[gidx_q];
  assign sel_last  = req_last[gidx_q];
  assign sel_addr  = req_addr[int'(gidx_q)*AW +: AW];
  assign sel_data  = req_data[int'(gidx_q)*DW +: DW];

  // gnt_q is zero outside BURST, so it alone qualifies the ack
  assign ack       = gnt_q & req & {NREQ{VGA_ready}};
  assign beat      = |ack;
  assign burst_end = !sel_req || (beat && (sel_last || cnt_q == CW'(MAX_BURST - 1)));

  // Scan downward so the candidate closest above ptr_q is the one kept
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

`ifdef FB_ARB_ADDR_CHECK_EN
  logic [7:0] err_cnt_q;
  assign in_range = 32'(sel_addr) < 32'(FB_DEPTH);
  assign err_cnt  = err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (state_q == BURST && beat && !in_range && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`else
  assign in_range = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gidx_q    <= '0;
      ptr_q     <= IW'(NREQ - 1);
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q <= BURST;
            gidx_q  <= pick_idx;
            gnt_q   <= NREQ'(1) << pick_idx;
          end
        end
        BURST: begin
          if (beat) begin
            wr_en_q   <= in_range;
            wr_addr_q <= sel_addr;
            wr_data_q <= sel_data;
            cnt_q     <= cnt_q + 1'b1;
          end
          if (burst_end) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= gidx_q;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q == BURST);

endmodule
